// File: rtl/mcu_playlist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcu_playlist_ctrl
// Description : Player control FSM. Drives the note player (play, reset_play)
//               and walks a playlist of NUM_SONGS entries with next/prev
//               skipping, repeat-one / repeat-all modes and end-of-list stop.
//               Optional shuffle on forward skips is enabled by defining the
//               MCU_SHUFFLE_EN macro (8-bit Fibonacci LFSR source).
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_playlist_ctrl #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_pause,
    input  logic              next,
    input  logic              prev,
    input  logic              song_done,
    input  logic [1:0]        repeat_mode,
    input  logic              shuffle,
    output logic              play,
    output logic              reset_play,
    output logic              nextsong,
    output logic              prevsong,
    output logic [SONG_W-1:0] song_sel
);

    localparam logic [2:0] c_ST_RESET   = 3'd0;
    localparam logic [2:0] c_ST_PAUSE   = 3'd1;
    localparam logic [2:0] c_ST_PLAY    = 3'd2;
    localparam logic [2:0] c_ST_RESTART = 3'd3;
    localparam logic [2:0] c_ST_NEXT    = 3'd4;
    localparam logic [2:0] c_ST_PREV    = 3'd5;

    localparam logic [SONG_W-1:0] c_LAST = SONG_W'(NUM_SONGS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [SONG_W-1:0] r_song_sel;
    logic [SONG_W-1:0] w_inc;
    logic [SONG_W-1:0] w_dec;
    logic [SONG_W-1:0] w_fwd;

    // Sequential neighbours of the current song, both wrapping at the list ends
    assign w_inc = (r_song_sel == c_LAST) ? '0 : r_song_sel + 1'b1;
    assign w_dec = (r_song_sel == '0) ? c_LAST : r_song_sel - 1'b1;

`ifdef MCU_SHUFFLE_EN
    logic [7:0]        r_lfsr;
    logic              w_lfsr_fb;
    logic [SONG_W-1:0] w_rand;

    // Free-running LFSR, taps 8,6,5,4, reseeded on reset
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // LFSR register: one step every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // A random pick equal to the current song is bumped so a skip always moves
    assign w_rand = SONG_W'(32'(r_lfsr) % NUM_SONGS);
    assign w_fwd  = !shuffle ? w_inc : ((w_rand == r_song_sel) ? w_inc : w_rand);
`else
    logic w_unused_shuffle;

    assign w_unused_shuffle = shuffle;
    assign w_fwd            = w_inc;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; play_pause beats next, next beats prev, buttons beat song_done
    always_comb begin
        w_next_state = c_ST_RESET;
        case (r_state)
            c_ST_RESET: w_next_state = c_ST_PAUSE;
            c_ST_PAUSE: begin
                if (play_pause)  w_next_state = c_ST_PLAY;
                else if (next)   w_next_state = c_ST_NEXT;
                else if (prev)   w_next_state = c_ST_PREV;
                else             w_next_state = c_ST_PAUSE;
            end
            c_ST_PLAY: begin
                if (play_pause)     w_next_state = c_ST_PAUSE;
                else if (next)      w_next_state = c_ST_NEXT;
                else if (prev)      w_next_state = c_ST_PREV;
                else if (song_done) begin
                    case (repeat_mode)
                        2'b01:   w_next_state = c_ST_RESTART;
                        2'b10:   w_next_state = c_ST_NEXT;
                        default: w_next_state = (r_song_sel == c_LAST) ? c_ST_RESET : c_ST_NEXT;
                    endcase
                end else begin
                    w_next_state = c_ST_PLAY;
                end
            end
            c_ST_NEXT, c_ST_PREV, c_ST_RESTART: w_next_state = c_ST_PLAY;
            default: w_next_state = c_ST_RESET;
        endcase
    end

    // Moore output decode
    always_comb begin
        play       = 1'b0;
        reset_play = 1'b0;
        nextsong   = 1'b0;
        prevsong   = 1'b0;
        case (r_state)
            c_ST_RESET:   reset_play = 1'b1;
            c_ST_PLAY:    play       = 1'b1;
            c_ST_RESTART: reset_play = 1'b1;
            c_ST_NEXT: begin
                nextsong   = 1'b1;
                reset_play = 1'b1;
            end
            c_ST_PREV: begin
                prevsong   = 1'b1;
                reset_play = 1'b1;
            end
            default: ;
        endcase
    end

    // Song index: cleared around RESET, stepped on the edge leaving NEXT/PREV
    always_ff @(posedge clk) begin
        if (reset) begin
            r_song_sel <= '0;
        end else if ((r_state == c_ST_RESET) || (w_next_state == c_ST_RESET)) begin
            r_song_sel <= '0;
        end else if (r_state == c_ST_NEXT) begin
            r_song_sel <= w_fwd;
        end else if (r_state == c_ST_PREV) begin
            r_song_sel <= w_dec;
        end
    end

    assign song_sel = r_song_sel;

endmodule
`default_nettype wire

// File: tb/tb_mcu_playlist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_playlist_ctrl
// Description : Self-checking bench for mcu_playlist_ctrl (default build,
//               NUM_SONGS=4). Vector table with scoreboard queue plus a
//               hand-written skip latency sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_playlist_ctrl;

    localparam int NUM_SONGS = 4;
    localparam int SONG_W    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              play_pause = 1'b0;
    logic              next = 1'b0;
    logic              prev = 1'b0;
    logic              song_done = 1'b0;
    logic [1:0]        repeat_mode = 2'b00;
    logic              shuffle = 1'b0;
    logic              play;
    logic              reset_play;
    logic              nextsong;
    logic              prevsong;
    logic [SONG_W-1:0] song_sel;

    int n_tests = 0;
    int n_fail  = 0;

    mcu_playlist_ctrl #(.NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .play_pause (play_pause),
        .next       (next),
        .prev       (prev),
        .song_done  (song_done),
        .repeat_mode(repeat_mode),
        .shuffle    (shuffle),
        .play       (play),
        .reset_play (reset_play),
        .nextsong   (nextsong),
        .prevsong   (prevsong),
        .song_sel   (song_sel)
    );

    always #5 clk = ~clk;

    // One clock of stimulus and the outputs expected right after that edge.
    // e_out = {play, reset_play, nextsong, prevsong}
    typedef struct {
        logic              rst;
        logic              pp;
        logic              nx;
        logic              pv;
        logic              done;
        logic [1:0]        mode;
        logic [3:0]        e_out;
        logic [SONG_W-1:0] e_sel;
    } vec_t;

    typedef struct {
        int                idx;
        logic [3:0]        e_out;
        logic [SONG_W-1:0] e_sel;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic rst, input logic pp, input logic nx, input logic pv,
                       input logic done, input logic [1:0] mode,
                       input logic [3:0] eo, input logic [SONG_W-1:0] es);
        vec_t v;
        v.rst = rst; v.pp = pp; v.nx = nx; v.pv = pv; v.done = done; v.mode = mode;
        v.e_out = eo; v.e_sel = es;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        reset = 1'b0; play_pause = 1'b0; next = 1'b0; prev = 1'b0; song_done = 1'b0;
        repeat_mode = 2'b00;
    endtask

    initial begin
        exp_t e;
        logic [3:0] got;
        int cyc;

        //   rst pp nx pv dn mode   out      sel
        add(1, 0, 0, 0, 0, 2'b00, 4'b0100, 0);  // RESET
        add(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);  // PAUSE
        add(0, 0, 0, 0, 1, 2'b00, 4'b0000, 0);  // song_done ignored in PAUSE
        add(0, 1, 0, 0, 0, 2'b00, 4'b1000, 0);  // PLAY
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 0);  // NEXT
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 1);
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 1);
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 2);
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 2);
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 3);
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 3);  // next at last song
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 0);  // wraps to 0
        add(0, 0, 0, 1, 0, 2'b00, 4'b0101, 0);  // PREV at 0
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 3);  // wraps to 3
        add(0, 0, 0, 0, 1, 2'b00, 4'b0100, 0);  // end of list -> RESET
        add(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);  // lands in PAUSE
        add(0, 1, 0, 0, 0, 2'b00, 4'b1000, 0);
        add(0, 0, 0, 1, 0, 2'b00, 4'b0101, 0);
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 3);
        add(0, 0, 0, 0, 1, 2'b10, 4'b0110, 3);  // repeat-all at last song
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 0);
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 0);
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 1);
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 1);
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 2);
        add(0, 0, 0, 0, 1, 2'b01, 4'b0100, 2);  // repeat-one -> RESTART
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 2);
        add(0, 0, 0, 0, 1, 2'b00, 4'b0110, 2);  // normal, not last -> NEXT
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 3);
        add(0, 0, 0, 0, 1, 2'b11, 4'b0100, 0);  // mode 11 acts as 00
        add(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
        add(0, 1, 0, 0, 0, 2'b00, 4'b1000, 0);
        add(0, 1, 1, 1, 0, 2'b00, 4'b0000, 0);  // play_pause beats next/prev
        add(0, 0, 1, 1, 0, 2'b00, 4'b0110, 0);  // next beats prev (from PAUSE)
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 1);
        add(0, 0, 1, 1, 0, 2'b00, 4'b0110, 1);  // next beats prev (from PLAY)
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 2);
        add(0, 0, 0, 1, 0, 2'b00, 4'b0101, 2);  // prev held three cycles
        add(0, 0, 0, 1, 0, 2'b00, 4'b1000, 1);  // ignored in PREV
        add(0, 0, 0, 1, 0, 2'b00, 4'b0101, 1);  // acts again in PLAY
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 0);
        add(0, 0, 1, 0, 0, 2'b00, 4'b0110, 0);
        add(0, 0, 0, 0, 0, 2'b00, 4'b1000, 1);
        add(1, 1, 0, 0, 0, 2'b00, 4'b0100, 0);  // reset mid-play wins
        add(0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst; play_pause = vecs[i].pp; next = vecs[i].nx;
            prev = vecs[i].pv; song_done = vecs[i].done; repeat_mode = vecs[i].mode;
            e.idx = i; e.e_out = vecs[i].e_out; e.e_sel = vecs[i].e_sel;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {play, reset_play, nextsong, prevsong};
            n_tests++;
            if (got !== e.e_out || song_sel !== e.e_sel) begin
                n_fail++;
                $display("FAIL vec%0d: outs got=%b exp=%b song_sel got=%0d exp=%0d",
                         e.idx, got, e.e_out, song_sel, e.e_sel);
            end
        end
        clear_inputs();

        // Skip latency: pulse next in PAUSE, play must rise 2 cycles later on song 1
        next = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            next = 1'b0;
            cyc++;
        end while (!play && cyc < 10);
        n_tests++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL latency: got=%0d cycles exp=2", cyc);
        end
        n_tests++;
        if (song_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL latency_sel: got=%0d exp=1", song_sel);
        end

        // Previous song from song 1 returns to 0 with prevsong strobe in between
        prev = 1'b1;
        @(posedge clk); #1;
        prev = 1'b0;
        n_tests++;
        if (prevsong !== 1'b1 || reset_play !== 1'b1 || play !== 1'b0) begin
            n_fail++;
            $display("FAIL prev_strobe: got prevsong=%b reset_play=%b play=%b exp 1 1 0",
                     prevsong, reset_play, play);
        end
        @(posedge clk); #1;
        n_tests++;
        if (play !== 1'b1 || prevsong !== 1'b0 || song_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL prev_done: got play=%b prevsong=%b sel=%0d exp 1 0 0",
                     play, prevsong, song_sel);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
